warp_table_param: RTL and testbench

Parametrised successor of the warp table. A single-clock FIFO of warp descriptors that feeds the warp scheduler. It adds configurable width and depth, an optional empty-FIFO bypass, an occupancy count, a programmable vacancy threshold, flush, and sticky overflow/underflow error flags. It sits between the warp-launch/re-enqueue logic (writer) and the scheduler issue stage (reader).

---
 rtl/warp_table_param.sv | 99 +++++++++
 tb/tb_warp_table_param.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/warp_table_param.sv
// Parametrised warp descriptor FIFO feeding the scheduler issue stage.
// Optional empty bypass, occupancy count, vacancy threshold, sticky errors.
module warp_table_param #(
  parameter int WIDTH     = 44,
  parameter int DEPTH     = 8,
  parameter int VACANT_TH = 2,
  parameter bit BYPASS_EN = 1'b1,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             read_en,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             fifo_vacant,
  output logic [CW-1:0]    count,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             act;
  logic             bypass;
  logic             do_pop;
  logic             do_push;
  logic             udf_set;
  logic             ovf_set;

  // Depth need not be a power of two, so wrap by compare-and-clear.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CW'(DEPTH));
  assign fifo_vacant = (CW'(DEPTH) - count) >= CW'(VACANT_TH);

  assign act     = !rst && !flush;
  assign bypass  = act && BYPASS_EN && read_en && write_en && fifo_empty;
  assign do_pop  = act && read_en && !fifo_empty;
  // A full FIFO still accepts a push when the head leaves the same cycle.
  assign do_push = act && write_en && !bypass && (!fifo_full || read_en);
  assign udf_set = act && read_en && fifo_empty && !bypass;
  assign ovf_set = act && write_en && fifo_full && !read_en;

  always_comb begin
    count_nxt = count;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      ovf_err    <= 1'b0;
      udf_err    <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_valid <= 1'b0;
      ovf_err    <= 1'b0;
      udf_err    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count      <= count_nxt;
      read_valid <= do_pop || bypass;
      if (bypass)
        read_data <= write_data;
      else if (do_pop)
        read_data <= mem[rd_ptr];
      if (ovf_set) ovf_err <= 1'b1;
      if (udf_set) udf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= write_data;
  end

endmodule

// File: tb/tb_warp_table_param.sv
// Directed bench for warp_table_param with a queue reference model
// and an expected-output scoreboard.
module tb_warp_table_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        read_en;
  logic        write_en;
  logic [43:0] write_data;
  logic [43:0] read_data;
  logic        read_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_vacant;
  logic [3:0]  count;
  logic        ovf_err;
  logic        udf_err;

  logic [43:0] nb_read_data;
  logic        nb_read_valid;
  logic        nb_fifo_empty;
  logic        nb_fifo_full;
  logic        nb_fifo_vacant;
  logic [3:0]  nb_count;
  logic        nb_ovf_err;
  logic        nb_udf_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [43:0] mdl[$];
  logic [43:0] exp_q[$];
  logic [43:0] m_rdata;
  logic        m_ovf;
  logic        m_udf;
  logic        exp_valid;

  always #5 clk = ~clk;

  warp_table_param #(
    .WIDTH(44), .DEPTH(8), .VACANT_TH(2), .BYPASS_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .read_en(read_en), .write_en(write_en),
    .write_data(write_data), .read_data(read_data),
    .read_valid(read_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_vacant(fifo_vacant),
    .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  warp_table_param #(
    .WIDTH(44), .DEPTH(8), .VACANT_TH(2), .BYPASS_EN(1'b0)
  ) dut_nb (
    .clk(clk), .rst(rst), .flush(flush),
    .read_en(read_en), .write_en(write_en),
    .write_data(write_data), .read_data(nb_read_data),
    .read_valid(nb_read_valid), .fifo_empty(nb_fifo_empty),
    .fifo_full(nb_fifo_full), .fifo_vacant(nb_fifo_vacant),
    .count(nb_count), .ovf_err(nb_ovf_err), .udf_err(nb_udf_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rs, input logic fl,
                      input logic re, input logic we,
                      input logic [43:0] wd);
    bit e;
    bit f;
    int sz;
    rst = rs; flush = fl; read_en = re;
    write_en = we; write_data = wd;
    exp_valid = 1'b0;
    e = (mdl.size() == 0);
    f = (mdl.size() == 8);
    if (rs) begin
      mdl.delete(); exp_q.delete();
      m_rdata = '0; m_ovf = 0; m_udf = 0;
    end else if (fl) begin
      mdl.delete(); m_ovf = 0; m_udf = 0;
    end else if (re && we && e) begin
      exp_q.push_back(wd);
      exp_valid = 1'b1;
    end else begin
      if (re && !e) begin
        exp_q.push_back(mdl.pop_front());
        exp_valid = 1'b1;
      end else if (re) begin
        m_udf = 1'b1;
      end
      if (we && (!f || re)) mdl.push_back(wd);
      else if (we) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("read_valid", 64'(read_valid), 64'(exp_valid));
    if (read_valid && exp_q.size() > 0) m_rdata = exp_q.pop_front();
    chk("read_data", 64'(read_data), 64'(m_rdata));
    sz = mdl.size();
    chk("count", 64'(count), 64'(sz));
    chk("fifo_empty", 64'(fifo_empty), 64'(sz == 0));
    chk("fifo_full", 64'(fifo_full), 64'(sz == 8));
    chk("fifo_vacant", 64'(fifo_vacant), 64'((8 - sz) >= 2));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    chk("udf_err", 64'(udf_err), 64'(m_udf));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; read_en = 1'b0;
    write_en = 1'b0; write_data = '0;
    m_rdata = '0; m_ovf = 0; m_udf = 0;

    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);

    // empty bypass, and the stored path on the non-bypass instance
    step(0, 0, 1, 1, 44'h123_4567_89AB);
    chk("nb_read_valid", 64'(nb_read_valid), 64'd0);
    chk("nb_count", 64'(nb_count), 64'd1);
    chk("nb_udf_err", 64'(nb_udf_err), 64'd1);
    step(0, 0, 0, 0, '0);

    for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, 44'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0);
    for (int i = 9; i <= 11; i++) step(0, 0, 0, 1, 44'(i));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);

    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 44'(32'h100 + i));
    step(0, 0, 1, 1, 44'hAA);
    step(0, 0, 0, 1, 44'hBB);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, '0);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);

    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 44'(32'h200 + i));
    step(0, 1, 0, 1, 44'hDEAD);
    step(0, 0, 0, 0, '0);

    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 44'(32'h300 + i));
    step(0, 0, 1, 0, '0);
    step(1, 0, 0, 1, 44'hBEEF);
    step(0, 0, 1, 1, 44'h777);
    step(0, 0, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
